// File: rtl/square_pkg.sv
`default_nettype none
// ============================================================================
// Module      : square_pkg
// Description : Shared slot layout, playfield constants and random-word helper
//               for the falling-squares motion engine.
// Revision    : 1.0 - initial release
// ============================================================================
package square_pkg;

    // Slot geometry: 40 bits per slot, 10-bit fields
    localparam int SLOT_W = 40;
    localparam int POS_W  = 10;
    localparam int SPD_W  = 10;

    // Default playfield configuration
    localparam int DEF_MAX_SQ   = 16;
    localparam int DEF_SCREEN_W = 640;
    localparam int DEF_SCREEN_H = 480;
    localparam int DEF_SQ_SIZE  = 16;

    // Only the low 14 bits of each slot's rotated random word are consumed
    localparam int RND_W = 14;

    // 32-bit Galois LFSR, polynomial x^32 + x^22 + x^2 + x + 1 (right-shifting form)
    localparam logic [31:0] LFSR_SEED = 32'hACE1_2B5F;
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    // Field order from MSB to LSB matches the packed slot word
    typedef struct packed {
        logic signed [SPD_W-1:0] speed_y;
        logic signed [SPD_W-1:0] speed_x;
        logic        [POS_W-1:0] pos_y;
        logic        [POS_W-1:0] pos_x;
    } slot_t;

    // Rotate the LFSR word left by rot (mod 32) and keep the bits a slot uses
    function automatic logic [RND_W-1:0] slot_rnd(input logic [31:0] word,
                                                  input int unsigned rot);
        logic [63:0] dbl;
        dbl = {word, word} << (rot % 32);
        return dbl[32 +: RND_W];
    endfunction

endpackage
`default_nettype wire

// File: rtl/square_slot.sv
`default_nettype none
// ============================================================================
// Module      : square_slot
// Description : Combinational spawn / move / bounce logic for one square slot.
// Revision    : 1.0 - initial release
// ============================================================================
module square_slot
    import square_pkg::*;
#(
    parameter int SCREEN_W = DEF_SCREEN_W,
    parameter int SCREEN_H = DEF_SCREEN_H,
    parameter int SQ_SIZE  = DEF_SQ_SIZE
) (
    input  logic [SLOT_W-1:0] slot_in,
    input  logic [RND_W-1:0]  rnd,
    input  logic              enable,
    input  logic              tick,
    output logic [SLOT_W-1:0] slot_out
);

    // Number of legal x positions for a freshly spawned square
    localparam int X_SPAN = SCREEN_W - SQ_SIZE + 1;
    // Largest legal top-left coordinate on each axis
    localparam logic signed [11:0] X_LIM = 12'(SCREEN_W - SQ_SIZE);
    localparam logic signed [11:0] Y_LIM = 12'(SCREEN_H - SQ_SIZE);

    slot_t             cur;
    slot_t             spawn;
    slot_t             moved;
    logic signed [11:0] nx;
    logic signed [11:0] ny;

    assign cur = slot_t'(slot_in);

    // Fresh square at the top edge with a random column and velocity
    always_comb begin
        spawn         = '0;
        spawn.pos_x   = POS_W'(32'(rnd[9:0]) % X_SPAN);
        spawn.pos_y   = '0;
        spawn.speed_y = SPD_W'(rnd[11:10]) + SPD_W'(1);
        // r[13:12] - 2, with the zero result replaced by +2 so it always drifts
        case (rnd[13:12])
            2'd0:    spawn.speed_x = -10'sd2;
            2'd1:    spawn.speed_x = -10'sd1;
            2'd2:    spawn.speed_x =  10'sd2;
            default: spawn.speed_x =  10'sd1;
        endcase
    end

    // Advance by one step, clamping to the walls and reflecting the velocity
    always_comb begin
        nx    = $signed({2'b00, cur.pos_x}) + $signed({{2{cur.speed_x[SPD_W-1]}}, cur.speed_x});
        ny    = $signed({2'b00, cur.pos_y}) + $signed({{2{cur.speed_y[SPD_W-1]}}, cur.speed_y});
        moved = cur;

        if (nx < 0) begin
            moved.pos_x   = '0;
            moved.speed_x = -cur.speed_x;
        end else if (nx > X_LIM) begin
            moved.pos_x   = X_LIM[POS_W-1:0];
            moved.speed_x = -cur.speed_x;
        end else begin
            moved.pos_x   = nx[POS_W-1:0];
        end

        if (ny < 0) begin
            moved.pos_y   = '0;
            moved.speed_y = -cur.speed_y;
        end else if (ny > Y_LIM) begin
            moved.pos_y   = Y_LIM[POS_W-1:0];
            moved.speed_y = -cur.speed_y;
        end else begin
            moved.pos_y   = ny[POS_W-1:0];
        end
    end

    // Choose hold, clear, spawn or move; an all-zero slot counts as empty
    always_comb begin
        if (!tick) begin
            slot_out = slot_in;
        end else if (!enable) begin
            slot_out = '0;
        end else if (slot_in == '0) begin
            slot_out = spawn;
        end else begin
            slot_out = moved;
        end
    end

endmodule
`default_nettype wire

// File: rtl/random_squares.sv
`default_nettype none
// ============================================================================
// Module      : random_squares
// Description : Spawn and motion engine for up to MAX_SQ falling squares.
//               Produces next-state slot data; the caller owns the register.
// Revision    : 1.0 - initial release
// ============================================================================
module random_squares
    import square_pkg::*;
#(
    parameter int MAX_SQ   = DEF_MAX_SQ,
    parameter int SCREEN_W = DEF_SCREEN_W,
    parameter int SCREEN_H = DEF_SCREEN_H,
    parameter int SQ_SIZE  = DEF_SQ_SIZE
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     refresh_tick,
    input  logic                     status,
    input  logic [5:0]               num_squares,
    input  logic [MAX_SQ*SLOT_W-1:0] position,
    output logic [MAX_SQ*SLOT_W-1:0] position_next
);

    logic                     tick_q;
    logic [31:0]              lfsr;
    logic                     tick;
    logic                     update;
    logic [5:0]               num_active;
    logic [MAX_SQ*SLOT_W-1:0] slots_next;

    // Previous level of the frame strobe for rising-edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_q <= 1'b0;
        end else begin
            tick_q <= refresh_tick;
        end
    end

    // Free-running Galois LFSR; a nonzero seed keeps it off the all-zero state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {1'b0, lfsr[31:1]} ^ (lfsr[0] ? LFSR_TAPS : 32'h0);
        end
    end

    assign tick       = refresh_tick & ~tick_q;
    assign update     = tick & status;
    assign num_active = (num_squares > 6'(MAX_SQ)) ? 6'(MAX_SQ) : num_squares;

    generate
        for (genvar i = 0; i < MAX_SQ; i++) begin : g_slot
            logic [RND_W-1:0] rnd;
            logic             enable;

            // Each slot sees the shared random word rotated by 3*i bits
            assign rnd    = slot_rnd(lfsr, 32'(3 * i));
            assign enable = (6'(i) < num_active);

            square_slot #(
                .SCREEN_W (SCREEN_W),
                .SCREEN_H (SCREEN_H),
                .SQ_SIZE  (SQ_SIZE)
            ) u_slot (
                .slot_in  (position[i*SLOT_W +: SLOT_W]),
                .rnd      (rnd),
                .enable   (enable),
                .tick     (update),
                .slot_out (slots_next[i*SLOT_W +: SLOT_W])
            );
        end
    endgenerate

    // Reset forces an empty playfield regardless of the external register
    assign position_next = reset ? slots_next : '0;

endmodule
`default_nettype wire

// File: tb/tb_random_squares.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_random_squares
// Description : Self-checking bench for random_squares against a behavioural
//               model of spawn, move, bounce, clear and freeze.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_random_squares;

    localparam int NSQ = 16;
    localparam int W   = NSQ * 40;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         refresh_tick = 1'b0;
    logic         status = 1'b0;
    logic [5:0]   num_squares = 6'd0;
    logic [W-1:0] pos_drv = '0;
    logic [W-1:0] fb_reg;
    logic         feedback = 1'b0;
    logic [W-1:0] position;
    logic [W-1:0] position_next;
    logic [31:0]  m_lfsr;

    int errors = 0;
    int checks = 0;

    assign position = feedback ? fb_reg : pos_drv;

    random_squares dut (
        .clk           (clk),
        .reset         (reset),
        .refresh_tick  (refresh_tick),
        .status        (status),
        .num_squares   (num_squares),
        .position      (position),
        .position_next (position_next)
    );

    always #5 clk = ~clk;

    // External game register closing the feedback loop
    always @(posedge clk) fb_reg <= position_next;

    // Reference random source: polynomial x^32+x^22+x^2+x+1, one step per clock
    function automatic logic [31:0] lfsr_step(input logic [31:0] x);
        logic lsb;
        lsb = x[0];
        x   = x >> 1;
        if (lsb) x = x ^ 32'h8020_0003;
        return x;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) m_lfsr <= 32'hACE1_2B5F;
        else        m_lfsr <= lfsr_step(m_lfsr);
    end

    function automatic logic [39:0] mk_slot(input int vy, input int vx, input int py, input int px);
        logic [9:0] a, b, c, d;
        a = 10'(vy); b = 10'(vx); c = 10'(py); d = 10'(px);
        return {a, b, c, d};
    endfunction

    function automatic logic [39:0] m_slot(input logic [39:0] s, input logic [31:0] r,
                                           input bit en, input bit upd);
        int px, py, vx, vy, nx, ny;
        if (!upd) return s;
        if (!en) return 40'd0;
        if (s == 40'd0) begin
            px = int'(r[9:0]) % 625;
            py = 0;
            vy = 1 + int'(r[11:10]);
            vx = int'(r[13:12]) - 2;
            if (vx == 0) vx = 2;
        end else begin
            px = int'(s[9:0]);
            py = int'(s[19:10]);
            vx = int'($signed(s[29:20]));
            vy = int'($signed(s[39:30]));
            nx = px + vx;
            ny = py + vy;
            if (nx < 0)        begin px = 0;   vx = -vx; end
            else if (nx > 624) begin px = 624; vx = -vx; end
            else               px = nx;
            if (ny < 0)        begin py = 0;   vy = -vy; end
            else if (ny > 464) begin py = 464; vy = -vy; end
            else               py = ny;
        end
        return mk_slot(vy, vx, py, px);
    endfunction

    function automatic logic [W-1:0] m_next(input logic [W-1:0] pos, input logic [31:0] lf,
                                            input bit st, input bit tk, input int num);
        logic [W-1:0] res;
        logic [31:0]  r;
        int n, k;
        n = (num > NSQ) ? NSQ : num;
        for (int i = 0; i < NSQ; i++) begin
            k = (3 * i) % 32;
            r = (k == 0) ? lf : ((lf << k) | (lf >> (32 - k)));
            res[i*40 +: 40] = m_slot(pos[i*40 +: 40], r, i < n, st && tk);
        end
        return res;
    endfunction

    function automatic logic [39:0] rand_active();
        int vx, vy;
        vx = $urandom_range(0, 12) - 6; if (vx == 0) vx = 3;
        vy = $urandom_range(0, 12) - 6; if (vy == 0) vy = -2;
        return mk_slot(vy, vx, $urandom_range(0, 480), $urandom_range(0, 640));
    endfunction

    function automatic logic [W-1:0] rand_pos();
        logic [W-1:0] p;
        for (int i = 0; i < NSQ; i++) begin
            case ($urandom_range(0, 3))
                0:       p[i*40 +: 40] = 40'd0;
                1:       p[i*40 +: 40] = {8'($urandom), 32'($urandom)};
                default: p[i*40 +: 40] = rand_active();
            endcase
        end
        return p;
    endfunction

    task automatic raise_tick();
        @(negedge clk);
        refresh_tick = 1'b1;
        #1;
    endtask

    task automatic lower_tick();
        @(negedge clk);
        refresh_tick = 1'b0;
    endtask

    task automatic test_reset();
        logic [W-1:0] p;
        reset = 1'b0; status = 1'b1; num_squares = 6'd16; pos_drv = '1;
        #2;
        checks++;
        if (position_next !== '0) begin
            errors++; $display("FAIL reset_clear got=%h exp=0", position_next[159:0]);
        end
        @(negedge clk);
        status = 1'b0; p = rand_pos(); pos_drv = p; reset = 1'b1;
        #1;
        checks++;
        if (position_next !== p) begin
            errors++; $display("FAIL reset_release_hold got=%h exp=%h", position_next[159:0], p[159:0]);
        end
        raise_tick();
        checks++;
        if (position_next !== p) begin
            errors++; $display("FAIL frozen_tick_hold got=%h exp=%h", position_next[159:0], p[159:0]);
        end
        lower_tick();
    endtask

    task automatic test_spawn();
        logic [W-1:0] exp;
        int vx, vy, px, py;
        status = 1'b1; num_squares = 6'd1; pos_drv = '0;
        for (int it = 0; it < 4; it++) begin
            raise_tick();
            exp = m_next(pos_drv, m_lfsr, 1'b1, 1'b1, 1);
            px = int'(position_next[9:0]);
            py = int'(position_next[19:10]);
            vx = int'($signed(position_next[29:20]));
            vy = int'($signed(position_next[39:30]));
            checks++;
            if (position_next !== exp) begin
                errors++; $display("FAIL spawn_exact got=%h exp=%h", position_next[39:0], exp[39:0]);
            end
            checks++;
            if (py != 0 || px > 624 || vy < 1 || vy > 4 || !(vx == -2 || vx == -1 || vx == 1 || vx == 2)) begin
                errors++; $display("FAIL spawn_range got px=%0d py=%0d vx=%0d vy=%0d", px, py, vx, vy);
            end
            checks++;
            if (position_next[W-1:40] !== '0) begin
                errors++; $display("FAIL spawn_others got nonzero exp=0");
            end
            lower_tick();
        end
    endtask

    task automatic test_move();
        logic [39:0] start, step1;
        start = mk_slot(3, 2, 100, 200);
        step1 = mk_slot(3, 2, 103, 202);
        status = 1'b1; num_squares = 6'd1;
        pos_drv = '0; pos_drv[39:0] = start;
        raise_tick();
        checks++;
        if (position_next[39:0] !== step1 || position_next[W-1:40] !== '0) begin
            errors++; $display("FAIL move_step got=%h exp=%h", position_next[39:0], step1);
        end
        lower_tick();
        // Hold the strobe high for four clocks through the feedback register
        @(negedge clk);
        feedback = 1'b1;
        refresh_tick = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (position[39:0] !== step1) begin
                errors++; $display("FAIL move_hold_once cyc=%0d got=%h exp=%h", c, position[39:0], step1);
            end
        end
        refresh_tick = 1'b0;
        @(negedge clk);
        feedback = 1'b0;
    endtask

    task automatic test_bounce();
        logic [39:0] ins [4];
        logic [39:0] outs [4];
        ins[0] = mk_slot( 1,  2, 100, 623); outs[0] = mk_slot( 1, -2, 101, 624);
        ins[1] = mk_slot(-3,  1,   1,  10); outs[1] = mk_slot( 3,  1,   0,  11);
        ins[2] = mk_slot( 2, -2,  50,   1); outs[2] = mk_slot( 2,  2,  52,   0);
        ins[3] = mk_slot( 4, -1, 463, 300); outs[3] = mk_slot(-4, -1, 464, 299);
        status = 1'b1; num_squares = 6'd1;
        for (int k = 0; k < 4; k++) begin
            pos_drv = '0; pos_drv[39:0] = ins[k];
            raise_tick();
            checks++;
            if (position_next[39:0] !== outs[k]) begin
                errors++; $display("FAIL bounce_%0d got=%h exp=%h", k, position_next[39:0], outs[k]);
            end
            lower_tick();
        end
    endtask

    task automatic test_disable();
        logic [W-1:0] p, exp;
        p = '0;
        p[39:0]   = mk_slot(1, 1, 50, 50);
        p[79:40]  = mk_slot(2, -1, 60, 70);
        p[119:80] = mk_slot(-1, 2, 80, 90);
        status = 1'b1; num_squares = 6'd3; pos_drv = p;
        raise_tick();
        exp = m_next(p, m_lfsr, 1'b1, 1'b1, 3);
        checks++;
        if (position_next !== exp) begin
            errors++; $display("FAIL three_move got=%h exp=%h", position_next[119:0], exp[119:0]);
        end
        lower_tick();
        num_squares = 6'd1;
        raise_tick();
        checks++;
        if (position_next[39:0] !== mk_slot(1, 1, 51, 51) || position_next[W-1:40] !== '0) begin
            errors++; $display("FAIL disable_clear got=%h exp=%h", position_next[119:0], {80'd0, mk_slot(1, 1, 51, 51)});
        end
        lower_tick();
    endtask

    task automatic test_clamp();
        logic [W-1:0] exp;
        int bad;
        status = 1'b1; num_squares = 6'd40; pos_drv = '0;
        raise_tick();
        exp = m_next(pos_drv, m_lfsr, 1'b1, 1'b1, 40);
        bad = 0;
        for (int i = 0; i < NSQ; i++)
            if (position_next[i*40 +: 40] == 40'd0 || position_next[i*40+10 +: 10] != 10'd0) bad++;
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL clamp_all_spawn got bad_slots=%0d exp=0", bad);
        end
        checks++;
        if (position_next !== exp) begin
            errors++; $display("FAIL clamp_exact got=%h exp=%h", position_next[159:0], exp[159:0]);
        end
        lower_tick();
    endtask

    task automatic test_freeze();
        logic [W-1:0] p;
        status = 1'b0; num_squares = 6'd16;
        p = rand_pos(); pos_drv = p;
        for (int k = 0; k < 3; k++) begin
            raise_tick();
            checks++;
            if (position_next !== p) begin
                errors++; $display("FAIL freeze_%0d got=%h exp=%h", k, position_next[159:0], p[159:0]);
            end
            lower_tick();
        end
    endtask

    task automatic test_random();
        logic [W-1:0] exp;
        int n;
        for (int it = 0; it < 30; it++) begin
            @(negedge clk);
            n = $urandom_range(0, 63);
            num_squares = 6'(n);
            status = ($urandom_range(0, 3) != 0);
            pos_drv = rand_pos();
            raise_tick();
            exp = m_next(pos_drv, m_lfsr, status, 1'b1, n);
            checks++;
            if (position_next !== exp) begin
                errors++; $display("FAIL random_%0d num=%0d got=%h exp=%h", it, n, position_next[199:0], exp[199:0]);
            end
            // Strobe still high a clock later: no second edge, so data holds
            @(posedge clk); #1;
            checks++;
            if (position_next !== pos_drv) begin
                errors++; $display("FAIL random_held_%0d got=%h exp=%h", it, position_next[199:0], pos_drv[199:0]);
            end
            lower_tick();
        end
    endtask

    task automatic test_async_reset();
        status = 1'b1; num_squares = 6'd16; pos_drv = rand_pos();
        refresh_tick = 1'b0;
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (position_next !== '0) begin
            errors++; $display("FAIL async_reset got=%h exp=0", position_next[159:0]);
        end
        @(negedge clk);
        reset = 1'b1;
        status = 1'b0;
        #1;
        checks++;
        if (position_next !== pos_drv) begin
            errors++; $display("FAIL after_reset_hold got=%h exp=%h", position_next[159:0], pos_drv[159:0]);
        end
    endtask

    initial begin
        test_reset();
        test_spawn();
        test_move();
        test_bounce();
        test_disable();
        test_clamp();
        test_freeze();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
